// File: rtl/motion_pkg.sv
// rtl/motion_pkg.sv - shared types and edge-code indices for the sprite motion controller
package motion_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MOVE    = 2'd1,
        ST_BLOCKED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam int EDGE_LEFT   = 3;
    localparam int EDGE_TOP    = 2;
    localparam int EDGE_RIGHT  = 1;
    localparam int EDGE_BOTTOM = 0;

endpackage

// File: rtl/sprite_axis_update.sv
// rtl/sprite_axis_update.sv - signed fixed-point add of one axis delta with clamp to pixel bounds
module sprite_axis_update #(
    parameter int POS_W     = 18,
    parameter int FRAC_BITS = 6,
    parameter int MIN_PX    = 0,
    parameter int MAX_PX    = 607
) (
    input  logic signed [POS_W-1:0] pos,
    input  logic signed [POS_W-1:0] delta,
    output logic signed [POS_W-1:0] pos_next
);

    localparam int LO_I = MIN_PX * (2 ** FRAC_BITS);
    localparam int HI_I = MAX_PX * (2 ** FRAC_BITS);
    localparam logic signed [POS_W:0] LO = LO_I[POS_W:0];
    localparam logic signed [POS_W:0] HI = HI_I[POS_W:0];

    // One guard bit so the sum cannot wrap before the clamp sees it.
    logic signed [POS_W:0] sum;
    logic signed [POS_W:0] clamped;

    always_comb begin
        sum = {pos[POS_W-1], pos} + {delta[POS_W-1], delta};
        if (sum < LO) begin
            clamped = LO;
        end else if (sum > HI) begin
            clamped = HI;
        end else begin
            clamped = sum;
        end
        pos_next = POS_W'(clamped);
    end

endmodule

// File: rtl/sprite_motion_ctrl.sv
// rtl/sprite_motion_ctrl.sv - per-frame keyboard stepping, collision push-back with directional lockout, clamp and respawn
module sprite_motion_ctrl
    import motion_pkg::*;
#(
    parameter int                FRAC_BITS     = 6,
    parameter int                SPEED         = 128,
    parameter int                PUSHBACK      = 128,
    parameter int                SLOW_PUSHBACK = 64,
    parameter int                N_COLL        = 4,
    parameter logic [N_COLL-1:0] SLOW_MASK     = 4'b0100,
    parameter int                BLOCK_FRAMES  = 4,
    parameter int                X_MIN         = 0,
    parameter int                X_MAX         = 607,
    parameter int                Y_MIN         = 0,
    parameter int                Y_MAX         = 447
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic                     Up_Move,
    input  logic                     Down_Move,
    input  logic                     Right_Move,
    input  logic                     Left_Move,
    input  logic                     speed_boost,
    input  logic [N_COLL-1:0]        collision,
    input  logic [3:0]               HitEdgeCode,
    input  logic [10:0]              INITIAL_X,
    input  logic [10:0]              INITIAL_Y,
    input  logic                     load_init,
    output logic signed [10:0]       topLeftX,
    output logic signed [10:0]       topLeftY,
    output logic                     moving,
    output logic                     blocked,
    output logic [1:0]               dir
);

    localparam int POS_W = 11 + FRAC_BITS + 1;
    localparam logic signed [POS_W-1:0] STEP_N = POS_W'(SPEED);
    localparam logic signed [POS_W-1:0] STEP_B = POS_W'(2 * SPEED);
    localparam logic signed [POS_W-1:0] PUSH_N = POS_W'(PUSHBACK);
    localparam logic signed [POS_W-1:0] PUSH_S = POS_W'(SLOW_PUSHBACK);
    localparam logic [3:0]              CNT_LOAD = 4'(BLOCK_FRAMES);

    logic signed [POS_W-1:0] pos_x, pos_y, x_next, y_next, dx, dy;
    state_t     state, state_nxt;
    dir_t       lock_dir, lock_nxt, dir_q, dir_nxt, key_dir, push_dir;
    logic [3:0] lock_cnt, cnt_nxt;
    logic       pushed, pushed_nxt, moving_nxt;
    logic       key_valid, edge_valid, step_ok, push_hit;
    logic signed [POS_W-1:0] step_amt, push_amt;

    always_comb begin
        key_valid = 1'b1;
        key_dir   = DIR_UP;
        case ({Up_Move, Down_Move, Left_Move, Right_Move})
            4'b1000: key_dir = DIR_UP;
            4'b0100: key_dir = DIR_DOWN;
            4'b0010: key_dir = DIR_LEFT;
            4'b0001: key_dir = DIR_RIGHT;
            default: key_valid = 1'b0;
        endcase
    end

    // Only a single touched edge is unambiguous; corners and opposite edges push nothing.
    always_comb begin
        edge_valid = 1'b1;
        push_dir   = DIR_UP;
        case (HitEdgeCode)
            4'b1 << EDGE_LEFT:   push_dir = DIR_LEFT;
            4'b1 << EDGE_RIGHT:  push_dir = DIR_RIGHT;
            4'b1 << EDGE_TOP:    push_dir = DIR_UP;
            4'b1 << EDGE_BOTTOM: push_dir = DIR_DOWN;
            default:             edge_valid = 1'b0;
        endcase
    end

    assign step_amt = speed_boost ? STEP_B : STEP_N;
    assign push_amt = (|(collision & SLOW_MASK)) ? PUSH_S : PUSH_N;
    assign step_ok  = key_valid && !(state == ST_BLOCKED && key_dir == lock_dir);
    assign push_hit = (|collision) && !pushed && edge_valid;

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = lock_cnt;
        lock_nxt   = lock_dir;
        pushed_nxt = pushed;
        moving_nxt = moving;
        dir_nxt    = dir_q;
        dx         = '0;
        dy         = '0;
        if (startOfFrame) begin
            pushed_nxt = 1'b0;
            moving_nxt = step_ok;
            if (step_ok) begin
                dir_nxt = key_dir;
                case (key_dir)
                    DIR_UP:    dy = -step_amt;
                    DIR_DOWN:  dy = step_amt;
                    DIR_LEFT:  dx = -step_amt;
                    DIR_RIGHT: dx = step_amt;
                endcase
            end
            if (state == ST_BLOCKED) begin
                cnt_nxt = lock_cnt - 4'd1;
                if (lock_cnt <= 4'd1) begin
                    cnt_nxt   = 4'd0;
                    state_nxt = ST_IDLE;
                end
            end else begin
                state_nxt = step_ok ? ST_MOVE : ST_IDLE;
            end
        end else if (push_hit) begin
            pushed_nxt = 1'b1;
            state_nxt  = ST_BLOCKED;
            cnt_nxt    = CNT_LOAD;
            lock_nxt   = push_dir;
            // Push away from the touched edge.
            case (push_dir)
                DIR_LEFT:  dx = push_amt;
                DIR_RIGHT: dx = -push_amt;
                DIR_UP:    dy = push_amt;
                DIR_DOWN:  dy = -push_amt;
            endcase
        end
    end

    sprite_axis_update #(
        .POS_W(POS_W), .FRAC_BITS(FRAC_BITS), .MIN_PX(X_MIN), .MAX_PX(X_MAX)
    ) u_axis_x (
        .pos(pos_x), .delta(dx), .pos_next(x_next)
    );

    sprite_axis_update #(
        .POS_W(POS_W), .FRAC_BITS(FRAC_BITS), .MIN_PX(Y_MIN), .MAX_PX(Y_MAX)
    ) u_axis_y (
        .pos(pos_y), .delta(dy), .pos_next(y_next)
    );

    always_ff @(posedge clk) begin
        if (!resetN || load_init) begin
            pos_x    <= {1'b0, INITIAL_X, {FRAC_BITS{1'b0}}};
            pos_y    <= {1'b0, INITIAL_Y, {FRAC_BITS{1'b0}}};
            state    <= ST_IDLE;
            lock_cnt <= 4'd0;
            lock_dir <= DIR_UP;
            pushed   <= 1'b0;
            moving   <= 1'b0;
            dir_q    <= DIR_UP;
        end else begin
            pos_x    <= x_next;
            pos_y    <= y_next;
            state    <= state_nxt;
            lock_cnt <= cnt_nxt;
            lock_dir <= lock_nxt;
            pushed   <= pushed_nxt;
            moving   <= moving_nxt;
            dir_q    <= dir_nxt;
        end
    end

    assign topLeftX = 11'(pos_x >>> FRAC_BITS);
    assign topLeftY = 11'(pos_y >>> FRAC_BITS);
    assign blocked  = (state == ST_BLOCKED);
    assign dir      = dir_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// tb/tb_sprite_motion_ctrl.sv - directed vector bench for sprite_motion_ctrl
module tb_sprite_motion_ctrl;

    logic              clk = 1'b0;
    logic              resetN;
    logic              startOfFrame;
    logic              Up_Move, Down_Move, Right_Move, Left_Move;
    logic              speed_boost;
    logic [3:0]        collision;
    logic [3:0]        HitEdgeCode;
    logic [10:0]       INITIAL_X, INITIAL_Y;
    logic              load_init;
    logic signed [10:0] topLeftX, topLeftY;
    logic              moving, blocked;
    logic [1:0]        dir;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_motion_ctrl dut (
        .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
        .Up_Move(Up_Move), .Down_Move(Down_Move), .Right_Move(Right_Move), .Left_Move(Left_Move),
        .speed_boost(speed_boost), .collision(collision), .HitEdgeCode(HitEdgeCode),
        .INITIAL_X(INITIAL_X), .INITIAL_Y(INITIAL_Y), .load_init(load_init),
        .topLeftX(topLeftX), .topLeftY(topLeftY), .moving(moving), .blocked(blocked), .dir(dir)
    );

    typedef struct {
        logic [3:0] keys;     // {up, down, left, right}
        logic       boost;
        logic [3:0] coll;
        logic [3:0] edg;
        int         frames;
        int         ex;
        int         ey;
        logic       em;
        logic [1:0] ed;
        logic       eb;
    } vec_t;

    vec_t vecs[16];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int ex, input int ey, input int em,
                           input int ed, input int eb);
        chk({tag, "_x"}, int'(topLeftX), ex);
        chk({tag, "_y"}, int'(topLeftY), ey);
        chk({tag, "_moving"}, int'(moving), em);
        chk({tag, "_dir"}, int'(dir), ed);
        chk({tag, "_blocked"}, int'(blocked), eb);
    endtask

    task automatic set_keys(input logic [3:0] k);
        {Up_Move, Down_Move, Left_Move, Right_Move} = k;
    endtask

    task automatic frame();
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        repeat (3) tick();
    endtask

    task automatic hit(input logic [3:0] c, input logic [3:0] e);
        collision   = c;
        HitEdgeCode = e;
        repeat (10) tick();
        collision   = '0;
        HitEdgeCode = '0;
        tick();
    endtask

    initial begin
        // keys boost coll edge frames  x    y   mv dir blk
        vecs[0]  = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 3, 106, 200, 1'b1, 2'd3, 1'b0};
        vecs[1]  = '{4'b0001, 1'b1, 4'b0000, 4'b0000, 1, 110, 200, 1'b1, 2'd3, 1'b0};
        vecs[2]  = '{4'b1001, 1'b0, 4'b0000, 4'b0000, 2, 110, 200, 1'b0, 2'd3, 1'b0};
        vecs[3]  = '{4'b0000, 1'b0, 4'b0001, 4'b1000, 0, 112, 200, 1'b0, 2'd3, 1'b1};
        vecs[4]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1, 112, 200, 1'b0, 2'd3, 1'b1};
        vecs[5]  = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 1, 112, 198, 1'b1, 2'd0, 1'b1};
        vecs[6]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1, 112, 198, 1'b0, 2'd0, 1'b1};
        vecs[7]  = '{4'b1000, 1'b0, 4'b0000, 4'b0000, 1, 112, 196, 1'b1, 2'd0, 1'b0};
        vecs[8]  = '{4'b0010, 1'b0, 4'b0000, 4'b0000, 1, 110, 196, 1'b1, 2'd2, 1'b0};
        vecs[9]  = '{4'b0000, 1'b0, 4'b0100, 4'b0001, 0, 110, 195, 1'b1, 2'd2, 1'b1};
        vecs[10] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 1, 110, 195, 1'b0, 2'd2, 1'b1};
        vecs[11] = '{4'b0000, 1'b0, 4'b0100, 4'b1001, 0, 110, 195, 1'b0, 2'd2, 1'b1};
        vecs[12] = '{4'b0000, 1'b0, 4'b0101, 4'b0010, 0, 109, 195, 1'b0, 2'd2, 1'b1};
        vecs[13] = '{4'b0100, 1'b0, 4'b0000, 4'b0000, 1, 109, 197, 1'b1, 2'd1, 1'b1};
        vecs[14] = '{4'b0001, 1'b0, 4'b0000, 4'b0000, 1, 109, 197, 1'b0, 2'd1, 1'b1};
        vecs[15] = '{4'b0000, 1'b0, 4'b0000, 4'b0000, 2, 109, 197, 1'b0, 2'd1, 1'b0};

        resetN       = 1'b0;
        startOfFrame = 1'b0;
        set_keys(4'b0000);
        speed_boost  = 1'b0;
        collision    = '0;
        HitEdgeCode  = '0;
        INITIAL_X    = 11'd100;
        INITIAL_Y    = 11'd200;
        load_init    = 1'b0;
        repeat (2) tick();
        resetN = 1'b1;
        tick();
        chk_all("reset", 100, 200, 0, 0, 0);

        for (int i = 0; i < 16; i++) begin
            set_keys(vecs[i].keys);
            speed_boost = vecs[i].boost;
            if (vecs[i].coll != 4'b0000) hit(vecs[i].coll, vecs[i].edg);
            for (int f = 0; f < vecs[i].frames; f++) frame();
            chk_all($sformatf("v%0d", i), vecs[i].ex, vecs[i].ey,
                    int'(vecs[i].em), int'(vecs[i].ed), int'(vecs[i].eb));
        end
        set_keys(4'b0000);
        speed_boost = 1'b0;

        // Right-edge clamp.
        INITIAL_X = 11'd606;
        INITIAL_Y = 11'd60;
        load_init = 1'b1;
        tick();
        load_init = 1'b0;
        chk_all("load606", 606, 60, 0, 0, 0);
        set_keys(4'b0001);
        frame();
        chk("clamp1_x", int'(topLeftX), 607);
        frame();
        chk("clamp2_x", int'(topLeftX), 607);
        set_keys(4'b0000);

        // Push-back past the right bound is clamped too; respawn aborts BLOCKED.
        hit(4'b0001, 4'b1000);
        chk("clamp_push_x", int'(topLeftX), 607);
        chk("clamp_push_blk", int'(blocked), 1);
        INITIAL_X = 11'd50;
        INITIAL_Y = 11'd60;
        load_init = 1'b1;
        tick();
        load_init = 1'b0;
        chk_all("load_blk", 50, 60, 0, 0, 0);

        // Frame pulse and collision in the same cycle: step first, push next cycle.
        set_keys(4'b1000);
        collision    = 4'b0001;
        HitEdgeCode  = 4'b0001;
        startOfFrame = 1'b1;
        tick();
        startOfFrame = 1'b0;
        chk("sof_coll_step_y", int'(topLeftY), 58);
        chk("sof_coll_step_blk", int'(blocked), 0);
        tick();
        collision   = '0;
        HitEdgeCode = '0;
        chk("sof_coll_push_y", int'(topLeftY), 56);
        chk("sof_coll_push_blk", int'(blocked), 1);
        tick();

        // Reset mid-move.
        set_keys(4'b0001);
        frame();
        chk("premove_x", int'(topLeftX), 52);
        INITIAL_X = 11'd70;
        INITIAL_Y = 11'd80;
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        set_keys(4'b0000);
        chk_all("midreset", 70, 80, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
Parametrised keyboard-driven sprite mover for player characters: doctor, and later a second player or AI-driven sprites on the same port set. It keeps the sprite position in fixed point and steps it once per frame from the direction keys. It resolves collisions from N_COLL independent sources by a single push-back per frame, then a timed BLOCKED lockout of the hit direction. It clamps to a playfield window and supports synchronous respawn. It sits between the key decoder/collision matrix and the sprite draw block.

Parameters:
FRAC_BITS, 6, fractional bits of the fixed-point position (1 px = 2^FRAC_BITS units)
SPEED, 128, normal step per frame in fixed-point units (2 px)
PUSHBACK, 128, push-back per collision event, normal sources
SLOW_PUSHBACK, 64, push-back for sources selected by SLOW_MASK
N_COLL, 4, number of collision source inputs
SLOW_MASK, 4'b0100, per-source select for SLOW_PUSHBACK (width N_COLL)
BLOCK_FRAMES, 4, frames the hit direction stays locked after a push-back (1..15)
X_MIN / X_MAX, 0 / 607, legal topLeftX range in pixels
Y_MIN / Y_MAX, 0 / 447, legal topLeftY range in pixels

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse per frame
Up_Move / Down_Move / Right_Move / Left_Move  in  1 each  key levels
speed_boost  in  1  step = 2*SPEED while high
collision  in  N_COLL  per-source collision pulses (pixel-time)
HitEdgeCode  in  4  [3]=left [2]=top [1]=right [0]=bottom edge of sprite touched
INITIAL_X / INITIAL_Y  in  11 each  spawn position in pixels
load_init  in  1  synchronous respawn
topLeftX / topLeftY  out  11 signed each  pixel position
moving  out  1  a step was applied at the last startOfFrame
blocked  out  1  FSM in BLOCKED
dir  out  2  last step direction: 0 up, 1 down, 2 left, 3 right

Behaviour:
- Clock is clk. Reset is resetN: synchronous, active-low, sampled on posedge clk only.
- Reset / load_init: pos = INITIAL*2^FRAC_BITS, state IDLE, lock counter 0, pushed flag 0, moving=0, dir=0, blocked=0. Reset has priority over load_init; load_init has priority over everything else, including mid-BLOCKED.
- Position regs are signed, 11+FRAC_BITS+1 bits. topLeftX/Y = pos >>> FRAC_BITS (floor). They are combinational from the regs, so they are visible one cycle after the update.
- Key decode: the step direction is valid only when exactly one key is high. Zero keys or two or more keys give no step, moving=0, and dir holds its value.
- Step, on startOfFrame only: pos += ±step on the decoded axis. The step is suppressed if the direction is locked (BLOCKED).
- After every update, pos is clamped to [MIN*2^FRAC_BITS, MAX*2^FRAC_BITS] per axis.
- Collision, cycles without startOfFrame, at most once per frame:
  - Trigger: any collision bit high while pushed==0.
  - Amount: PUSHBACK, or SLOW_PUSHBACK if any active source is in SLOW_MASK (SLOW wins on mixed).
  - Effect: pushed=1, state goes to BLOCKED, counter = BLOCK_FRAMES. lock_dir is latched from the edge.
  - pushed clears on startOfFrame.
- Edge to push mapping:
  - [3] only on the X axis (no [0]/[2]): X += amount, lock left.
  - [1] only: X -= amount, lock right.
  - [2] only on the Y axis (no [1]/[3]): Y += amount, lock up.
  - [0] only: Y -= amount, lock down.
  - Corner codes (bits on both axes) and opposite-edge codes ([3]&[1] or [2]&[0]) give no push and no state change.
- FSM:
  - IDLE -> MOVE on a valid step.
  - MOVE -> IDLE on a frame with no step.
  - IDLE/MOVE -> BLOCKED on a push.
  - BLOCKED: counter decrements on each startOfFrame; on reaching 0 go to IDLE. Non-locked directions still step.
  - A new push in BLOCKED reloads the counter and lock_dir.
- startOfFrame and a collision in the same cycle: step only, and the collision is ignored that cycle. Collision inputs persist across the sprite's pixels, so the collision is taken on a later cycle.

Decomposition:
- motion_pkg: state_t {IDLE, MOVE, BLOCKED}; dir_t; edge bit index constants EDGE_LEFT=3, EDGE_TOP=2, EDGE_RIGHT=1, EDGE_BOTTOM=0.
- Sub-module sprite_axis_update, one instance per axis: signed add of step/push with clamp to min/max, parametrised on FRAC_BITS and bounds.

Test Plan:
- Reset with INITIAL=(100,200) -> topLeft=(100,200), moving=0, blocked=0, dir=0.
- Right_Move held over 3 startOfFrame pulses -> X=106, Y=200, dir=3, moving=1. Then the same with speed_boost=1 for 1 frame -> X=110.
- Right_Move+Up_Move together for 2 frames -> position unchanged, moving=0.
- collision[0]=1, HitEdgeCode=4'b1000 held 10 cycles mid-frame -> X +2 exactly once, blocked=1. Left_Move ignored for 4 frames while Up_Move still steps. blocked=0 after the 4th startOfFrame.
- collision[2]=1 (slow source), HitEdgeCode=4'b0001 -> Y -1 px. Same stimulus with HitEdgeCode=4'b1001 -> no change.
- X=606 with Right_Move -> X=607, then held at 607. load_init with INITIAL=(50,60) during BLOCKED -> (50,60), blocked=0 next cycle. resetN low for 1 cycle mid-move -> spawn values.
